bin_a_bcd_seq: RTL

- Sequential binary-to-BCD converter (shift-add-3 / double-dabble) that sits directly upstream of the 8-digit seven-segment display driver.
- Takes a 32-bit calculator result, signed or unsigned, and produces 8 packed BCD digits on `bcd_out`, so the display shows decimal instead of hex.
- Sign and overflow are reported on separate flags for LEDs; on overflow the display shows "EEEEEEEE".

---
 rtl/calc_pkg.sv | 19 +
 rtl/bcd_ajuste.sv | 14 +
 rtl/bin_a_bcd_seq.sv | 131 +++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator display path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package calc_pkg;

    localparam int WIDTH_IN   = 32;
    localparam int DIGITS_OUT = 8;
    localparam int DIGITS_INT = 10;

    localparam logic [4*DIGITS_OUT-1:0] BCD_ERR     = 32'hEEEE_EEEE;
    localparam logic [WIDTH_IN-1:0]     MAX_DISPLAY = 32'd99_999_999;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        FINISH
    } state_t;

endpackage

// File: rtl/bcd_ajuste.sv
// One double-dabble correction cell: adds 3 to a BCD digit that is 5 or more.
// Latency: combinational.
// Backpressure: none.
//
// Ports: dig_in  - BCD digit before the shift
//        dig_out - corrected digit, ready to be shifted left
module bcd_ajuste (
    input  logic [3:0] dig_in,
    output logic [3:0] dig_out
);

    assign dig_out = (dig_in >= 4'd5) ? (dig_in + 4'd3) : dig_in;

endmodule

// File: rtl/bin_a_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble) feeding the 8-digit display.
// Latency: start sampled at edge 0, results and done pulse after edge 33.
// Backpressure: none; start is only sampled in IDLE, requests while busy are dropped.
//
// Ports: clk, rst_n (async, active-low)
//        start, valor_entrada[31:0], es_signed  - conversion request and operand
//        bcd_out[31:0], negativo, desborde      - held results for display/LEDs
//        busy, done                             - status; done is a one-cycle pulse
module bin_a_bcd_seq
    import calc_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [WIDTH_IN-1:0]     valor_entrada,
    input  logic                    es_signed,
    output logic [4*DIGITS_OUT-1:0] bcd_out,
    output logic                    negativo,
    output logic                    desborde,
    output logic                    busy,
    output logic                    done
);

    state_t                    state_q, state_d;
    logic [4:0]                cnt_q, cnt_d;
    logic [WIDTH_IN-1:0]       bin_q, bin_d;
    logic [4*DIGITS_INT-1:0]   acc_q, acc_d;
    logic                      sign_q, sign_d;
    logic [4*DIGITS_OUT-1:0]   bcd_out_q, bcd_out_d;
    logic                      negativo_q, negativo_d;
    logic                      desborde_q, desborde_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic [4*DIGITS_INT-1:0]   acc_adj;
    logic                      ovf;

    for (genvar g = 0; g < DIGITS_INT; g++) begin : g_adj
        bcd_ajuste u_adj (
            .dig_in  (acc_q[4*g +: 4]),
            .dig_out (acc_adj[4*g +: 4])
        );
    end

    // Anything in the two digits beyond the display means the value exceeds 99_999_999.
    assign ovf = |acc_q[4*DIGITS_INT-1:4*DIGITS_OUT];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bin_d      = bin_q;
        acc_d      = acc_q;
        sign_d     = sign_q;
        bcd_out_d  = bcd_out_q;
        negativo_d = negativo_q;
        desborde_d = desborde_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // -2^31 negates to itself, which reads correctly as 2^31 unsigned.
                    if (es_signed && valor_entrada[WIDTH_IN-1]) begin
                        bin_d  = ~valor_entrada + 1'b1;
                        sign_d = 1'b1;
                    end else begin
                        bin_d  = valor_entrada;
                        sign_d = 1'b0;
                    end
                    acc_d   = '0;
                    cnt_d   = 5'd0;
                    busy_d  = 1'b1;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                {acc_d, bin_d} = {acc_adj, bin_q} << 1;
                cnt_d          = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                // Outputs only move here, so the display never sees partial sums.
                negativo_d = sign_q;
                desborde_d = ovf;
                bcd_out_d  = ovf ? BCD_ERR : acc_q[4*DIGITS_OUT-1:0];
                busy_d     = 1'b0;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            bin_q      <= '0;
            acc_q      <= '0;
            sign_q     <= 1'b0;
            bcd_out_q  <= '0;
            negativo_q <= 1'b0;
            desborde_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bin_q      <= bin_d;
            acc_q      <= acc_d;
            sign_q     <= sign_d;
            bcd_out_q  <= bcd_out_d;
            negativo_q <= negativo_d;
            desborde_q <= desborde_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bcd_out  = bcd_out_q;
    assign negativo = negativo_q;
    assign desborde = desborde_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
